// File: rtl/pace_pingpong_oup_if.sv
// HWPE stream interface used by pace_pingpong_oup for its packed-word source port.
// Carries data/strb with a valid/ready handshake; a word moves when valid & ready.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/pace_pingpong_oup.sv
// Packs NumBeats engine result beats into one wide HWPE stream word (write-side ping-pong).
// Optional partial-word flush is enabled by defining PACE_PINGPONG_OUP_FLUSH_EN.
module pace_pingpong_oup #(
    parameter int unsigned NumRows      = 8,
    parameter int unsigned InpDataWidth = 16,
    parameter int unsigned NumBeats     = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   clear_i,
    input  logic                                   enable_i,
    input  logic [NumRows-1:0][InpDataWidth-1:0]   input_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic                                   flush_i,
    hwpe_stream_intf_stream.source                 output_o
);
    localparam int unsigned BeatWidth     = NumRows * InpDataWidth;
    localparam int unsigned OupDataWidth  = BeatWidth * NumBeats;
    localparam int unsigned StrbWidth     = OupDataWidth / 8;
    localparam int unsigned BeatStrbWidth = BeatWidth / 8;
    localparam int unsigned CntWidth      = $clog2(NumBeats);
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumBeats - 1);

    logic [CntWidth-1:0]     cnt_q;
    logic [OupDataWidth-1:0] asm_q;
    logic [OupDataWidth-1:0] asm_next;
    logic [OupDataWidth-1:0] out_data_q;
    logic [StrbWidth-1:0]    out_strb_q;
    logic [StrbWidth-1:0]    strb_next;
    logic                    out_valid_q;
    logic                    in_hs;
    logic                    last_beat;
    logic                    out_free;
    logic                    drain;
    logic                    xfer_full;
    logic                    flush_xfer;
    logic                    xfer;

    assign last_beat = (cnt_q == LastCnt);
    assign drain     = out_valid_q & output_o.ready;
    assign out_free  = ~out_valid_q | output_o.ready;

    // Only the word-closing beat can stall; reset forces ready low immediately.
    assign ready_o   = ~rst_i & enable_i & ~clear_i
                     & ~(last_beat & out_valid_q & ~output_o.ready);
    assign in_hs     = valid_i & ready_o;
    assign xfer_full = in_hs & last_beat;
    assign xfer      = xfer_full | flush_xfer;

    always_comb begin
        asm_next = asm_q;
        for (int k = 0; k < NumBeats; k++) begin
            if (in_hs && (cnt_q == CntWidth'(k))) begin
                asm_next[k*BeatWidth +: BeatWidth] = input_i;
            end
        end
    end

`ifdef PACE_PINGPONG_OUP_FLUSH_EN
    localparam int unsigned FillWidth = CntWidth + 1;
    logic [FillWidth-1:0] fill_cnt;

    // A flush closes whatever is filled, including a beat accepted this cycle.
    assign flush_xfer = flush_i & ((cnt_q != '0) | in_hs) & out_free;
    assign fill_cnt   = {1'b0, cnt_q} + FillWidth'(in_hs);

    always_comb begin
        strb_next = '0;
        for (int k = 0; k < NumBeats; k++) begin
            if (FillWidth'(k) < fill_cnt) begin
                strb_next[k*BeatStrbWidth +: BeatStrbWidth] = '1;
            end
        end
    end
`else
    logic unused_flush;
    assign unused_flush = flush_i;
    assign flush_xfer   = 1'b0;
    assign strb_next    = '1;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q       <= '0;
            asm_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // Assembly is zeroed on transfer so a later partial word has clean unfilled beats.
            if (xfer) begin
                cnt_q      <= '0;
                asm_q      <= '0;
                out_data_q <= asm_next;
                out_strb_q <= strb_next;
            end else if (in_hs) begin
                cnt_q <= cnt_q + CntWidth'(1);
                asm_q <= asm_next;
            end
            if (xfer) begin
                out_valid_q <= 1'b1;
            end else if (drain) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign output_o.valid = out_valid_q;
    assign output_o.data  = out_data_q;
    assign output_o.strb  = out_strb_q;
endmodule

// File: tb/tb_pace_pingpong_oup.sv
// Directed bench for pace_pingpong_oup with default parameters (8 rows x 16 bit, 2 beats).
module tb_pace_pingpong_oup;
    typedef logic [7:0][15:0] beat_t;

    logic   clk = 1'b0;
    logic   rst_i, clear_i, enable_i, valid_i, flush_i, ready_o;
    beat_t  input_i;
    logic [255:0] exp_w;
    int     n_vec = 0;
    int     n_err = 0;

    hwpe_stream_intf_stream #(.DATA_WIDTH(256)) out_if ();

    always #5 clk = ~clk;

    pace_pingpong_oup dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .clear_i  (clear_i),
        .enable_i (enable_i),
        .input_i  (input_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .flush_i  (flush_i),
        .output_o (out_if)
    );

    function automatic beat_t mk_beat(input logic [15:0] base);
        beat_t b;
        for (int r = 0; r < 8; r++) b[r] = base + 16'(r);
        return b;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; clear_i = 1'b0; enable_i = 1'b1; valid_i = 1'b1; flush_i = 1'b0;
        input_i = mk_beat(16'h1234); out_if.ready = 1'b1;
        step(); step(); #1;
        n_vec++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_if.valid); end
        n_vec++; if (out_if.strb !== 32'h0) begin n_err++; $display("FAIL reset_strb: got %h want 0", out_if.strb); end
        n_vec++; if (out_if.data !== 256'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_if.data); end
        n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        step(); rst_i = 1'b0; valid_i = 1'b0;
    endtask

    task automatic test_streaming();
        step(); out_if.ready = 1'b1; valid_i = 1'b1; input_i = mk_beat(16'h0001); #1;
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL stream_rdy0: got %b want 1", ready_o); end
        n_vec++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL stream_v0: got %b want 0", out_if.valid); end
        step(); input_i = mk_beat(16'h0011); #1;
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL stream_rdy1: got %b want 1", ready_o); end
        n_vec++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL stream_v1: got %b want 0", out_if.valid); end
        step(); input_i = mk_beat(16'h0021); #1;
        exp_w = {mk_beat(16'h0011), mk_beat(16'h0001)};
        n_vec++; if (out_if.valid !== 1'b1) begin n_err++; $display("FAIL stream_vA: got %b want 1", out_if.valid); end
        n_vec++; if (out_if.data !== exp_w) begin n_err++; $display("FAIL stream_dA: got %h want %h", out_if.data, exp_w); end
        n_vec++; if (out_if.data[15:0] !== 16'h0001) begin n_err++; $display("FAIL stream_lo: got %h want 0001", out_if.data[15:0]); end
        n_vec++; if (out_if.data[143:128] !== 16'h0011) begin n_err++; $display("FAIL stream_b1: got %h want 0011", out_if.data[143:128]); end
        n_vec++; if (out_if.strb !== 32'hFFFFFFFF) begin n_err++; $display("FAIL stream_strb: got %h want ffffffff", out_if.strb); end
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL stream_rdy2: got %b want 1", ready_o); end
        step(); input_i = mk_beat(16'h0031); #1;
        n_vec++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL stream_gap: got %b want 0", out_if.valid); end
        step(); valid_i = 1'b0; #1;
        exp_w = {mk_beat(16'h0031), mk_beat(16'h0021)};
        n_vec++; if (out_if.valid !== 1'b1) begin n_err++; $display("FAIL stream_vB: got %b want 1", out_if.valid); end
        n_vec++; if (out_if.data !== exp_w) begin n_err++; $display("FAIL stream_dB: got %h want %h", out_if.data, exp_w); end
        step(); #1;
        n_vec++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL stream_end: got %b want 0", out_if.valid); end
    endtask

    task automatic test_backpressure();
        step(); out_if.ready = 1'b0; valid_i = 1'b1; input_i = mk_beat(16'h0101);
        step(); input_i = mk_beat(16'h0111); #1;
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL bp_last_empty: got %b want 1", ready_o); end
        step(); input_i = mk_beat(16'h0121); #1;
        exp_w = {mk_beat(16'h0111), mk_beat(16'h0101)};
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL bp_beat3: got %b want 1", ready_o); end
        n_vec++; if (out_if.data !== exp_w) begin n_err++; $display("FAIL bp_dA0: got %h want %h", out_if.data, exp_w); end
        step(); input_i = mk_beat(16'h0131); #1;
        n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_beat4_held: got %b want 0", ready_o); end
        step(); #1;
        n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_beat4_held2: got %b want 0", ready_o); end
        n_vec++; if (out_if.valid !== 1'b1) begin n_err++; $display("FAIL bp_vA: got %b want 1", out_if.valid); end
        n_vec++; if (out_if.data !== exp_w) begin n_err++; $display("FAIL bp_dA1: got %h want %h", out_if.data, exp_w); end
        step(); out_if.ready = 1'b1; #1;
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b want 1", ready_o); end
        n_vec++; if (out_if.data !== exp_w) begin n_err++; $display("FAIL bp_dA2: got %h want %h", out_if.data, exp_w); end
        step(); valid_i = 1'b0; #1;
        exp_w = {mk_beat(16'h0131), mk_beat(16'h0121)};
        n_vec++; if (out_if.valid !== 1'b1) begin n_err++; $display("FAIL bp_vB: got %b want 1", out_if.valid); end
        n_vec++; if (out_if.data !== exp_w) begin n_err++; $display("FAIL bp_dB: got %h want %h", out_if.data, exp_w); end
        step(); #1;
        n_vec++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL bp_end: got %b want 0", out_if.valid); end
    endtask

    task automatic test_enable();
        step(); out_if.ready = 1'b0; valid_i = 1'b1; input_i = mk_beat(16'h0201);
        step(); input_i = mk_beat(16'h0211);
        step(); enable_i = 1'b0; input_i = mk_beat(16'h0301); #1;
        n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL en_ready0: got %b want 0", ready_o); end
        step(); #1;
        n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL en_ready1: got %b want 0", ready_o); end
        step(); out_if.ready = 1'b1; #1;
        n_vec++; if (out_if.valid !== 1'b1) begin n_err++; $display("FAIL en_pending: got %b want 1", out_if.valid); end
        step(); #1;
        n_vec++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL en_drained: got %b want 0", out_if.valid); end
        step(); enable_i = 1'b1; input_i = mk_beat(16'h0301);
        step(); input_i = mk_beat(16'h0311);
        step(); valid_i = 1'b0; #1;
        exp_w = {mk_beat(16'h0311), mk_beat(16'h0301)};
        n_vec++; if (out_if.data !== exp_w) begin n_err++; $display("FAIL en_word: got %h want %h", out_if.data, exp_w); end
    endtask

    task automatic test_clear();
        step(); out_if.ready = 1'b0; valid_i = 1'b1; input_i = mk_beat(16'h0401);
        step(); input_i = mk_beat(16'h0411);
        step(); input_i = mk_beat(16'h0421);
        step(); valid_i = 1'b1; clear_i = 1'b1; #1;
        n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL clr_ready: got %b want 0", ready_o); end
        step(); valid_i = 1'b0; clear_i = 1'b0; #1;
        n_vec++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b want 0", out_if.valid); end
        step(); out_if.ready = 1'b1; valid_i = 1'b1; input_i = mk_beat(16'h0501);
        step(); input_i = mk_beat(16'h0511);
        step(); valid_i = 1'b0; #1;
        exp_w = {mk_beat(16'h0511), mk_beat(16'h0501)};
        n_vec++; if (out_if.data !== exp_w) begin n_err++; $display("FAIL clr_word: got %h want %h", out_if.data, exp_w); end
    endtask

    task automatic test_async_reset();
        step(); out_if.ready = 1'b0; valid_i = 1'b1; input_i = mk_beat(16'h0601);
        step(); input_i = mk_beat(16'h0611);
        step(); input_i = mk_beat(16'h0621);
        step(); valid_i = 1'b0; #2; rst_i = 1'b1; #1;
        n_vec++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", out_if.valid); end
        n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL arst_ready: got %b want 0", ready_o); end
        n_vec++; if (out_if.strb !== 32'h0) begin n_err++; $display("FAIL arst_strb: got %h want 0", out_if.strb); end
        step(); rst_i = 1'b0; out_if.ready = 1'b1;
        step(); valid_i = 1'b1; input_i = mk_beat(16'h0701);
        step(); input_i = mk_beat(16'h0711);
        step(); valid_i = 1'b0; #1;
        exp_w = {mk_beat(16'h0711), mk_beat(16'h0701)};
        n_vec++; if (out_if.valid !== 1'b1) begin n_err++; $display("FAIL arst_v: got %b want 1", out_if.valid); end
        n_vec++; if (out_if.data !== exp_w) begin n_err++; $display("FAIL arst_word: got %h want %h", out_if.data, exp_w); end
    endtask

    task automatic test_flush();
        beat_t b;
        for (int r = 0; r < 8; r++) b[r] = 16'hAAAA;
        step(); out_if.ready = 1'b1; flush_i = 1'b1; #1;
        step(); flush_i = 1'b0; #1;
        n_vec++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL flush_idle: got %b want 0", out_if.valid); end
        step(); valid_i = 1'b1; input_i = b;
        step(); valid_i = 1'b0; flush_i = 1'b1;
        step(); flush_i = 1'b0; #1;
`ifdef PACE_PINGPONG_OUP_FLUSH_EN
        n_vec++; if (out_if.valid !== 1'b1) begin n_err++; $display("FAIL flush_valid: got %b want 1", out_if.valid); end
        n_vec++; if (out_if.strb !== 32'h0000FFFF) begin n_err++; $display("FAIL flush_strb: got %h want 0000ffff", out_if.strb); end
        n_vec++; if (out_if.data[255:128] !== 128'h0) begin n_err++; $display("FAIL flush_upper: got %h want 0", out_if.data[255:128]); end
        n_vec++; if (out_if.data[127:0] !== b) begin n_err++; $display("FAIL flush_lower: got %h want %h", out_if.data[127:0], b); end
`else
        n_vec++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL noflush_valid: got %b want 0", out_if.valid); end
        step(); #1;
        n_vec++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL noflush_valid2: got %b want 0", out_if.valid); end
`endif
        step(); clear_i = 1'b1;
        step(); clear_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_enable();
        test_clear();
        test_async_reset();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
